// File: rtl/mem_access_ctrl.sv
// Request sequencer in front of the 256x16 data RAM: single-word writes and 1..16-word read bursts.
// Optional perf counters (perf_reads/perf_writes/perf_clear) exist only when MEM_ACCESS_CTRL_PERF_EN is defined.
module mem_access_ctrl #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 16,
  parameter int LEN_W  = 4
) (
  input  logic              clock,
  input  logic              resetn,
  // Handshake: a transfer happens on the rising edge where valid && ready; the source
  // holds valid and its payload until then, and ready never depends on valid.
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [LEN_W-1:0]  req_len,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_last,
  output logic              wr_done,
  output logic [ADDR_W-1:0] mem_address,
  output logic [DATA_W-1:0] mem_data,
  output logic              mem_wren,
  input  logic [DATA_W-1:0] mem_q,
  output logic [1:0]        dbg_state,
  output logic              busy
`ifdef MEM_ACCESS_CTRL_PERF_EN
  ,
  input  logic              perf_clear,
  output logic [15:0]       perf_reads,
  output logic [15:0]       perf_writes
`endif
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WRITE = 2'd1,
    READ  = 2'd2,
    DRAIN = 2'd3
  } state_t;

  localparam logic [LEN_W:0]  LEN_ONE  = 1;
  localparam logic [ADDR_W-1:0] ADDR_ONE = 1;

  state_t            state;
  logic [LEN_W:0]    remaining;
  logic              cap_q;
  logic              cap_last_q;
  logic              b1_valid;
  logic              b1_last;
  logic [DATA_W-1:0] b1_data;

  logic       pop;
  logic       accept;
  logic       issue;
  logic       drain_done;
  logic [1:0] occ;

  // occ counts buffered words plus the word still in the RAM pipeline; an issue is
  // allowed only when it cannot overflow the 2-entry buffer by the time it lands.
  always_comb begin
    pop        = rsp_valid && rsp_ready;
    accept     = req_valid && req_ready;
    occ        = {1'b0, rsp_valid} + {1'b0, b1_valid} + {1'b0, cap_q};
    issue      = (state == READ) && ((occ - {1'b0, pop}) < 2'd2);
    drain_done = (state == DRAIN) && !cap_q && !b1_valid && (!rsp_valid || pop);
  end

  assign req_ready = resetn && (state == IDLE) && !rsp_valid && !b1_valid;
  assign dbg_state = state;

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state       <= IDLE;
      remaining   <= '0;
      cap_q       <= 1'b0;
      cap_last_q  <= 1'b0;
      mem_address <= '0;
      mem_data    <= '0;
      mem_wren    <= 1'b0;
      wr_done     <= 1'b0;
      busy        <= 1'b0;
    end else begin
      mem_wren   <= 1'b0;
      wr_done    <= 1'b0;
      cap_q      <= issue;
      cap_last_q <= issue && (remaining == LEN_ONE);
      case (state)
        IDLE: begin
          busy <= accept;
          if (accept) begin
            mem_address <= req_addr;
            if (req_write) begin
              state    <= WRITE;
              mem_data <= req_wdata;
              mem_wren <= 1'b1;
              wr_done  <= 1'b1;
            end else begin
              state     <= READ;
              remaining <= {1'b0, req_len} + LEN_ONE;
            end
          end
        end
        WRITE: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
        READ: begin
          busy <= 1'b1;
          if (issue) begin
            mem_address <= mem_address + ADDR_ONE;
            remaining   <= remaining - LEN_ONE;
            if (remaining == LEN_ONE) state <= DRAIN;
          end
        end
        DRAIN: begin
          busy <= !drain_done;
          if (drain_done) state <= IDLE;
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

  // Head entry doubles as the response output registers; b1 is the second slot.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      rsp_valid <= 1'b0;
      rsp_rdata <= '0;
      rsp_last  <= 1'b0;
      b1_valid  <= 1'b0;
      b1_data   <= '0;
      b1_last   <= 1'b0;
    end else if (pop) begin
      if (b1_valid) begin
        rsp_valid <= 1'b1;
        rsp_rdata <= b1_data;
        rsp_last  <= b1_last;
        b1_valid  <= cap_q;
        b1_data   <= mem_q;
        b1_last   <= cap_last_q;
      end else begin
        rsp_valid <= cap_q;
        rsp_rdata <= mem_q;
        rsp_last  <= cap_q && cap_last_q;
      end
    end else if (cap_q) begin
      if (!rsp_valid) begin
        rsp_valid <= 1'b1;
        rsp_rdata <= mem_q;
        rsp_last  <= cap_last_q;
      end else begin
        b1_valid <= 1'b1;
        b1_data  <= mem_q;
        b1_last  <= cap_last_q;
      end
    end
  end

`ifdef MEM_ACCESS_CTRL_PERF_EN
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      perf_reads  <= '0;
      perf_writes <= '0;
    end else if (perf_clear) begin
      perf_reads  <= '0;
      perf_writes <= '0;
    end else begin
      if (pop && (perf_reads != 16'hFFFF)) perf_reads <= perf_reads + 16'd1;
      if ((state == WRITE) && (perf_writes != 16'hFFFF)) perf_writes <= perf_writes + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Bench for mem_access_ctrl: RAM model, transaction-level response/write model, directed scenarios.
module tb_mem_access_ctrl;

  logic        clock;
  logic        resetn;
  logic        req_valid, req_ready, req_write;
  logic [7:0]  req_addr;
  logic [3:0]  req_len;
  logic [15:0] req_wdata;
  logic        rsp_valid, rsp_ready, rsp_last;
  logic [15:0] rsp_rdata;
  logic        wr_done;
  logic [7:0]  mem_address;
  logic [15:0] mem_data;
  logic        mem_wren;
  logic [15:0] mem_q;
  logic [1:0]  dbg_state;
  logic        busy;
`ifdef MEM_ACCESS_CTRL_PERF_EN
  logic        perf_clear;
  logic [15:0] perf_reads, perf_writes;
`endif

  mem_access_ctrl dut (
    .clock(clock), .resetn(resetn),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_addr(req_addr), .req_len(req_len), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata), .rsp_last(rsp_last),
    .wr_done(wr_done), .mem_address(mem_address), .mem_data(mem_data), .mem_wren(mem_wren),
    .mem_q(mem_q), .dbg_state(dbg_state), .busy(busy)
`ifdef MEM_ACCESS_CTRL_PERF_EN
    , .perf_clear(perf_clear), .perf_reads(perf_reads), .perf_writes(perf_writes)
`endif
  );

  // ---------------- clock / reset / cycle count ----------------
  int cyc = 0;
  initial clock = 1'b0;
  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  // ---------------- RAM model: synchronous read, old data on same-cycle write ----------------
  logic [15:0] ram [256];
  logic [15:0] ref_mem [256];
  always @(posedge clock) begin
    mem_q <= ram[mem_address];
    if (mem_wren) ram[mem_address] = mem_data;
  end

  // ---------------- checking ----------------
  int n_checks = 0;
  int n_errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Expected response stream {last, data} and the single outstanding write.
  logic [16:0] exp_q[$];
  logic [16:0] e;
  logic [23:0] wr_exp;
  logic [7:0]  ra;
  int          wr_due = -10, first_due = -10, ready_due = -10;
  logic        prev_stall = 1'b0;
  logic [15:0] prev_data;
  logic        prev_last;
  logic        busy_exp;

  always @(negedge clock) begin
    if (!resetn) begin
      exp_q.delete();
      wr_due = -10; first_due = -10; ready_due = -10;
      prev_stall = 1'b0;
    end else begin
      busy_exp = (exp_q.size() != 0) || (cyc == wr_due);
      chk("busy", busy, busy_exp);
      chk("req_ready", req_ready, !busy_exp);
      chk("mem_wren", mem_wren, cyc == wr_due);
      chk("wr_done", wr_done, cyc == wr_due);
      if (cyc == wr_due) begin
        chk("mem_address_wr", mem_address, wr_exp[23:16]);
        chk("mem_data_wr", mem_data, wr_exp[15:0]);
      end
      if (cyc < first_due) chk("rsp_early", rsp_valid, 0);
      if (cyc == first_due) chk("rsp_first_latency", rsp_valid, 1);
      if (cyc == ready_due) chk("req_ready_after_last", req_ready, 1);
      if (prev_stall) begin
        chk("stall_valid", rsp_valid, 1);
        chk("stall_rdata", rsp_rdata, prev_data);
        chk("stall_last", rsp_last, prev_last);
      end
      if (rsp_valid && rsp_ready) begin
        if (exp_q.size() == 0) chk("rsp_unexpected", rsp_valid, 0);
        else begin
          e = exp_q.pop_front();
          chk("rsp_rdata", rsp_rdata, e[15:0]);
          chk("rsp_last", rsp_last, e[16]);
          if (e[16]) ready_due = cyc + 1;
        end
      end
      prev_stall = rsp_valid && !rsp_ready;
      prev_data  = rsp_rdata;
      prev_last  = rsp_last;
      if (req_valid && req_ready) begin
        if (req_write) begin
          ref_mem[req_addr] = req_wdata;
          wr_exp = {req_addr, req_wdata};
          wr_due = cyc + 1;
        end else begin
          for (int i = 0; i <= int'(req_len); i++) begin
            ra = req_addr + 8'(i);
            exp_q.push_back({(i == int'(req_len)), ref_mem[ra]});
          end
          first_due = cyc + 3;
        end
      end
    end
  end

  // ---------------- driver tasks (called at posedge+1) ----------------
  task automatic do_write(input logic [7:0] a, input logic [15:0] d, output int acc);
    req_write = 1'b1; req_addr = a; req_wdata = d; req_len = 4'd0; req_valid = 1'b1;
    acc = -1;
    for (int k = 0; k < 100; k++) begin
      @(negedge clock);
      if (req_ready) begin acc = cyc; break; end
    end
    if (acc < 0) chk("write_accept_timeout", req_ready, 1);
    @(posedge clock); #1;
    req_valid = 1'b0;
  endtask

  task automatic do_read(input logic [7:0] a, input logic [3:0] l, output int acc);
    req_write = 1'b0; req_addr = a; req_len = l; req_valid = 1'b1;
    acc = -1;
    for (int k = 0; k < 100; k++) begin
      @(negedge clock);
      if (req_ready) begin acc = cyc; break; end
    end
    if (acc < 0) chk("read_accept_timeout", req_ready, 1);
    @(posedge clock); #1;
    req_valid = 1'b0;
  endtask

  task automatic wait_cycle(input int c);
    for (int k = 0; k < 1000 && cyc < c; k++) begin
      @(posedge clock); #1;
    end
  endtask

  task automatic wait_idle();
    int k;
    for (k = 0; k < 200; k++) begin
      @(posedge clock); #1;
      if (req_ready) break;
    end
    if (k == 200) chk("idle_timeout", req_ready, 1);
  endtask

  // ---------------- watchdog ----------------
  initial begin
    #200000;
    n_errors++;
    $display("FAIL watchdog: simulation did not complete in time");
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  // ---------------- directed scenarios ----------------
  int acc, acc_w;
  logic [5:0] pat;

  initial begin
    for (int i = 0; i < 256; i++) begin
      ram[i] = 16'(i) ^ 16'h5A00;
      ref_mem[i] = 16'(i) ^ 16'h5A00;
    end
    ram[254] = 16'h11FE; ref_mem[254] = 16'h11FE;
    ram[255] = 16'h11FF; ref_mem[255] = 16'h11FF;
    ram[0]   = 16'h1100; ref_mem[0]   = 16'h1100;
    ram[1]   = 16'h1101; ref_mem[1]   = 16'h1101;

    resetn = 1'b0; req_valid = 1'b0; req_write = 1'b0; req_addr = '0; req_len = '0;
    req_wdata = '0; rsp_ready = 1'b0;
`ifdef MEM_ACCESS_CTRL_PERF_EN
    perf_clear = 1'b0;
`endif
    repeat (2) @(posedge clock);
    #1;
    chk("rst_req_ready", req_ready, 0);
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_rsp_last", rsp_last, 0);
    chk("rst_wr_done", wr_done, 0);
    chk("rst_mem_wren", mem_wren, 0);
    chk("rst_mem_address", mem_address, 0);
    chk("rst_mem_data", mem_data, 0);
    chk("rst_busy", busy, 0);
    chk("rst_state", dbg_state, 0);
    resetn = 1'b1;
    rsp_ready = 1'b1;
    @(posedge clock); #1;
    chk("post_rst_req_ready", req_ready, 1);

    // Single write then read-back.
    do_write(8'h10, 16'hBEEF, acc);
    chk("wr_mem_wren", mem_wren, 1);
    chk("wr_mem_address", mem_address, 8'h10);
    chk("wr_mem_data", mem_data, 16'hBEEF);
    chk("wr_done_pulse", wr_done, 1);
    @(posedge clock); #1;
    chk("wr_mem_wren_off", mem_wren, 0);
    chk("wr_done_off", wr_done, 0);
    do_read(8'h10, 4'd0, acc);
    wait_cycle(acc + 2);
    chk("rd0_not_yet", rsp_valid, 0);
    wait_cycle(acc + 3);
    chk("rd0_valid", rsp_valid, 1);
    chk("rd0_data", rsp_rdata, 16'hBEEF);
    chk("rd0_last", rsp_last, 1);
    wait_idle();

    // Preload 0x20..0x23 through the controller, then stream them back.
    for (int i = 0; i < 4; i++) do_write(8'h20 + 8'(i), 16'(i + 1), acc);
    wait_idle();
    do_read(8'h20, 4'd3, acc);
    for (int i = 0; i < 4; i++) begin
      wait_cycle(acc + 3 + i);
      chk("burst4_valid", rsp_valid, 1);
      chk("burst4_data", rsp_rdata, 16'(i + 1));
      chk("burst4_last", rsp_last, i == 3);
    end
    // A request held during the burst is only taken the cycle after the final pop.
    do_write(8'h33, 16'h5555, acc_w);
    chk("holdoff_accept_cycle", acc_w, acc + 7);
    wait_idle();

    // Same burst with a stalling consumer.
    rsp_ready = 1'b0;
    pat = 6'b101001;
    do_read(8'h20, 4'd3, acc);
    for (int i = 0; i < 24; i++) begin
      rsp_ready = pat[i % 6];
      @(posedge clock); #1;
    end
    rsp_ready = 1'b1;
    wait_idle();
    chk("stall_burst_drained", exp_q.size(), 0);

    // Address wrap 0xFE -> 0x01.
    do_read(8'hFE, 4'd3, acc);
    wait_cycle(acc + 1); chk("wrap_addr0", mem_address, 8'hFE);
    wait_cycle(acc + 2); chk("wrap_addr1", mem_address, 8'hFF);
    wait_cycle(acc + 3); chk("wrap_addr2", mem_address, 8'h00);
    chk("wrap_data0", rsp_rdata, 16'h11FE);
    wait_cycle(acc + 4); chk("wrap_addr3", mem_address, 8'h01);
    wait_cycle(acc + 6); chk("wrap_data3", rsp_rdata, 16'h1101);
    chk("wrap_last", rsp_last, 1);
    wait_idle();

    // Full 16-word burst timing.
    do_read(8'h40, 4'd15, acc);
    wait_cycle(acc + 18);
    chk("b16_final_valid", rsp_valid, 1);
    chk("b16_final_last", rsp_last, 1);
    chk("b16_final_data", rsp_rdata, 16'h4F ^ 16'h5A00);
    wait_cycle(acc + 19);
    chk("b16_done_valid", rsp_valid, 0);
    chk("b16_done_ready", req_ready, 1);

    // Reset in the middle of a burst.
    do_read(8'h40, 4'd15, acc);
    wait_cycle(acc + 6);
    #2;
    resetn = 1'b0;
    #1;
    chk("midrst_rsp_valid", rsp_valid, 0);
    chk("midrst_mem_wren", mem_wren, 0);
    chk("midrst_wr_done", wr_done, 0);
    chk("midrst_busy", busy, 0);
    chk("midrst_req_ready", req_ready, 0);
    @(posedge clock); #1;
    resetn = 1'b1;
    @(posedge clock); #1;
    chk("postrst_req_ready", req_ready, 1);
    do_read(8'h10, 4'd0, acc);
    wait_cycle(acc + 3);
    chk("postrst_valid", rsp_valid, 1);
    chk("postrst_data", rsp_rdata, 16'hBEEF);
    wait_idle();

`ifdef MEM_ACCESS_CTRL_PERF_EN
    perf_clear = 1'b1;
    @(posedge clock); #1;
    perf_clear = 1'b0;
    chk("perf_cleared_r", perf_reads, 0);
    chk("perf_cleared_w", perf_writes, 0);
    for (int i = 0; i < 3; i++) do_write(8'h50 + 8'(i), 16'hA000 + 16'(i), acc);
    wait_idle();
    do_read(8'h50, 4'd4, acc);
    wait_idle();
    chk("perf_writes_3", perf_writes, 3);
    chk("perf_reads_5", perf_reads, 5);
    do_write(8'h53, 16'hA003, acc);
    perf_clear = 1'b1;
    @(posedge clock); #1;
    perf_clear = 1'b0;
    chk("perf_clear_priority", perf_writes, 0);
    force dut.perf_writes = 16'hFFFF;
    #1;
    release dut.perf_writes;
    do_write(8'h54, 16'hA004, acc);
    wait_idle();
    chk("perf_saturate", perf_writes, 16'hFFFF);
`endif

    repeat (3) @(posedge clock);
    #1;
    chk("final_queue_empty", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/mem_access_ctrl.md
Name: mem_access_ctrl

Overview:
Request sequencer sitting directly upstream of the 256x16 data memory wrapper. It drives that wrapper's address, data and write-enable pins, and captures its synchronous read data. It also serves single-word writes and 1..16-word sequential read bursts for the ALU/evaluator through a valid/ready request port and a valid/ready response port. A 2-entry response buffer absorbs the RAM's fixed read latency, so reads stream at one word per cycle under backpressure without loss.

Parameters:
ADDR_W, 8, memory address width (256 words)
DATA_W, 16, memory word width
LEN_W, 4, burst length field width; burst = req_len+1 words

Ports:
clock  in  1  system clock, rising edge
resetn  in  1  asynchronous active-low reset
req_valid  in  1  request present
req_ready  out  1  controller can accept a request
req_write  in  1  1 = single-word write, 0 = read burst
req_addr  in  ADDR_W  start address
req_len  in  LEN_W  read burst length minus one; ignored for writes
req_wdata  in  DATA_W  write data
rsp_valid  out  1  read word available
rsp_ready  in  1  consumer accepts read word
rsp_rdata  out  DATA_W  read word
rsp_last  out  1  marks final word of burst
wr_done  out  1  one-cycle pulse when write is committed
mem_address  out  ADDR_W  to memory address
mem_data  out  DATA_W  to memory write data
mem_wren  out  1  to memory write enable
mem_q  in  DATA_W  from memory read data; valid the cycle after the address is clocked in
busy  out  1  state != IDLE or response buffer non-empty

Behaviour:
- Reset (async, resetn=0): state IDLE; req_ready=0 while resetn=0, 1 from the first cycle after release. rsp_valid=0, rsp_last=0, wr_done=0, mem_wren=0, mem_address=0, mem_data=0, busy=0. The response buffer and all counters are cleared.
- All outputs are registered except req_ready, which is state==IDLE && buffer empty.
- Acceptance: a request is accepted on a rising edge with req_valid && req_ready. Fields are sampled only at acceptance.
- States: IDLE, WRITE, READ, DRAIN.
- IDLE:
  - Accepted write -> WRITE.
  - Accepted read -> READ. Latch remaining = req_len+1 and next_addr = req_addr.
- WRITE: one cycle. mem_address=addr, mem_data=wdata, mem_wren=1 and wr_done=1 in that same cycle. Next state IDLE. mem_wren is never high outside WRITE.
- READ:
  - Each issue cycle drives mem_address=next_addr, then next_addr+=1 modulo 256 (0xFF wraps to 0x00) and remaining-=1.
  - Issue rule: a word is issued only if (buffered words + issued-not-yet-captured words - words popped this cycle) < 2. No word is ever dropped.
  - When the last word is issued -> DRAIN.
- Capture: mem_q is written into the buffer on the edge ending the cycle after issue.
- DRAIN: wait until all issued words are captured and popped, then IDLE.
- Latency and throughput: read accepted in cycle N gives first rsp_valid in cycle N+3. With rsp_ready held high, one word per cycle thereafter. A 16-word burst completes rsp in cycle N+18.
- Response port:
  - rsp_valid stays high with rsp_rdata/rsp_last stable until rsp_ready; the word is popped on valid&&ready.
  - rsp_last is high only on the burst's final word; a len=0 read has rsp_last on its only word.
- Write then read: the write commits in WRITE. A read accepted afterwards returns the new data (RAM read-during-write is never exercised because states are exclusive).
- Reset mid-burst: outstanding words are discarded, rsp_valid drops immediately, and no wr_done is emitted.
- req_valid high while busy: held off by req_ready=0; no effect.

Optional Feature:
MEM_ACCESS_CTRL_PERF_EN
- Defined:
  - Adds outputs perf_reads[15:0] (words returned to consumer) and perf_writes[15:0] (writes committed).
  - Both increment by 1 per event, saturate at 0xFFFF and reset to 0 on resetn.
  - Adds input perf_clear (synchronous, active-high), which zeroes both and takes priority over a same-cycle increment.
- Undefined: these ports and counters are absent; all other behaviour is identical.

Test Plan:
- Write addr 0x10 data 0xBEEF -> mem_wren=1 for exactly 1 cycle with mem_address=0x10 and mem_data=0xBEEF; wr_done pulse in the same cycle. Then read addr 0x10 len 0 -> rsp_rdata=0xBEEF, rsp_last=1, rsp_valid in cycle N+3.
- Preload 0x20..0x23 = 1,2,3,4; read addr 0x20 len 3 with rsp_ready=1 -> rsp 1,2,3,4 on 4 consecutive cycles; rsp_last only on 4; req_ready returns high the cycle after the final pop.
- Same burst with rsp_ready toggling 1,0,0,1,0,1... -> data order 1,2,3,4 preserved, no duplicates or losses; rsp_rdata stable while stalled.
- Read addr 0xFE len 3 -> mem_address sequence 0xFE,0xFF,0x00,0x01; data matches preload.
- Assert resetn=0 in the middle of a 16-word burst -> rsp_valid=0 and mem_wren=0 asynchronously. After release, req_ready=1 and a new len-0 read returns correct data.
- PERF_EN build: 3 writes + 5-word burst -> perf_writes=3, perf_reads=5. perf_clear together with an increment -> 0. Force 0xFFFF -> holds at 0xFFFF.
